// File: rtl/s_axi_read_banked.sv
// AXI-Lite read-only slave with two register banks: bank0 holds local read-only
// sources, bank1 forwards reads through a request/ready port with a bounded wait.
module s_axi_read_banked #(
  parameter int unsigned ADDR_WIDTH   = 16,
  parameter int unsigned DATA_WIDTH   = 32,
  parameter int unsigned INDEX_WIDTH  = 2,
  parameter int unsigned CNT_WIDTH    = INDEX_WIDTH,
  parameter int unsigned STATUS_WIDTH = 4,
  parameter int unsigned TIMEOUT      = 16,
  parameter logic [31:0] VERSION      = 32'h0002_0000
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [ADDR_WIDTH-1:0]   S_AXI_ARADDR,
  input  logic                    S_AXI_ARVALID,
  output logic                    S_AXI_ARREADY,
  output logic [DATA_WIDTH-1:0]   S_AXI_RDATA,
  output logic [1:0]              S_AXI_RRESP,
  output logic                    S_AXI_RVALID,
  input  logic                    S_AXI_RREADY,
  input  logic [STATUS_WIDTH-1:0] bank0_status,
  input  logic [CNT_WIDTH-1:0]    bank0_main_cnt,
  input  logic [CNT_WIDTH-1:0]    bank0_end_cnt,
  output logic                    b1_req,
  output logic [INDEX_WIDTH-1:0]  b1_index,
  output logic [3:0]              b1_field,
  input  logic [DATA_WIDTH-1:0]   b1_rdata,
  input  logic                    b1_ready,
  output logic [15:0]             err_cnt
);

  localparam int unsigned REG_WIDTH  = ADDR_WIDTH - 8;
  localparam int unsigned TCNT_WIDTH = 8;
  localparam logic [1:0]  RESP_OKAY   = 2'b00;
  localparam logic [1:0]  RESP_SLVERR = 2'b10;
  localparam logic [1:0]  RESP_DECERR = 2'b11;

  typedef enum logic [1:0] {IDLE, B1_WAIT, RESP} state_t;

  state_t                  state_q, state_d;
  logic                    rvalid_q, rvalid_d;
  logic [DATA_WIDTH-1:0]   rdata_q, rdata_d;
  logic [1:0]              rresp_q, rresp_d;
  logic                    b1_req_q, b1_req_d;
  logic [INDEX_WIDTH-1:0]  b1_index_q, b1_index_d;
  logic [3:0]              b1_field_q, b1_field_d;
  logic [15:0]             err_cnt_q, err_cnt_d;
  logic [TCNT_WIDTH-1:0]   tcnt_q, tcnt_d;

  logic [1:0]              ar_bank;
  logic [REG_WIDTH-1:0]    ar_reg;
  logic [3:0]              ar_field;
  logic [INDEX_WIDTH-1:0]  ar_index;
  logic                    ar_hs;
  logic                    r_hs;
  logic                    unused_addr;

  assign ar_bank     = S_AXI_ARADDR[ADDR_WIDTH-1:ADDR_WIDTH-2];
  assign ar_reg      = S_AXI_ARADDR[ADDR_WIDTH-3:6];
  assign ar_field    = S_AXI_ARADDR[5:2];
  assign ar_index    = S_AXI_ARADDR[6+INDEX_WIDTH-1:6];
  assign unused_addr = ^S_AXI_ARADDR[1:0];

  // Accept when idle, or in the same cycle the pending response is consumed.
  assign S_AXI_ARREADY = S_AXI_ARVALID && !reset &&
                         ((state_q == IDLE) || ((state_q == RESP) && S_AXI_RREADY));
  assign ar_hs = S_AXI_ARVALID && S_AXI_ARREADY;
  assign r_hs  = rvalid_q && S_AXI_RREADY;

  always_comb begin
    state_d    = state_q;
    rvalid_d   = rvalid_q;
    rdata_d    = rdata_q;
    rresp_d    = rresp_q;
    b1_req_d   = b1_req_q;
    b1_index_d = b1_index_q;
    b1_field_d = b1_field_q;
    err_cnt_d  = err_cnt_q;
    tcnt_d     = tcnt_q;

    if (r_hs && (rresp_q != RESP_OKAY) && (err_cnt_q != 16'hFFFF)) begin
      err_cnt_d = err_cnt_q + 16'd1;
    end

    case (state_q)
      B1_WAIT: begin
        if (b1_ready) begin
          rdata_d  = b1_rdata;
          rresp_d  = RESP_OKAY;
          rvalid_d = 1'b1;
          b1_req_d = 1'b0;
          tcnt_d   = '0;
          state_d  = RESP;
        end else if (tcnt_q == TCNT_WIDTH'(TIMEOUT - 1)) begin
          rdata_d  = '0;
          rresp_d  = RESP_SLVERR;
          rvalid_d = 1'b1;
          b1_req_d = 1'b0;
          tcnt_d   = '0;
          state_d  = RESP;
        end else begin
          tcnt_d = tcnt_q + TCNT_WIDTH'(1);
        end
      end
      RESP: begin
        if (S_AXI_RREADY) begin
          rvalid_d = 1'b0;
          state_d  = IDLE;
        end
      end
      default: ;
    endcase

    // A new address overrides the IDLE/RESP outcome above.
    if (ar_hs) begin
      rvalid_d = 1'b1;
      rdata_d  = '0;
      rresp_d  = RESP_OKAY;
      state_d  = RESP;
      case (ar_bank)
        2'b00: begin
          if (ar_reg < REG_WIDTH'(4)) begin
            case (ar_reg[1:0])
              2'd0:    rdata_d = DATA_WIDTH'(VERSION);
              2'd1:    rdata_d = DATA_WIDTH'(bank0_status);
              2'd2:    rdata_d = DATA_WIDTH'(bank0_main_cnt);
              default: rdata_d = DATA_WIDTH'(bank0_end_cnt);
            endcase
          end else begin
            rresp_d = RESP_SLVERR;
          end
        end
        2'b01: begin
          if (ar_field >= 4'd6) begin
            rresp_d = RESP_SLVERR;
          end else begin
            rvalid_d   = 1'b0;
            b1_req_d   = 1'b1;
            b1_index_d = ar_index;
            b1_field_d = ar_field;
            tcnt_d     = '0;
            state_d    = B1_WAIT;
          end
        end
        default: rresp_d = RESP_DECERR;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      rvalid_q   <= 1'b0;
      rdata_q    <= '0;
      rresp_q    <= '0;
      b1_req_q   <= 1'b0;
      b1_index_q <= '0;
      b1_field_q <= '0;
      err_cnt_q  <= '0;
      tcnt_q     <= '0;
    end else begin
      state_q    <= state_d;
      rvalid_q   <= rvalid_d;
      rdata_q    <= rdata_d;
      rresp_q    <= rresp_d;
      b1_req_q   <= b1_req_d;
      b1_index_q <= b1_index_d;
      b1_field_q <= b1_field_d;
      err_cnt_q  <= err_cnt_d;
      tcnt_q     <= tcnt_d;
    end
  end

  assign S_AXI_RVALID = rvalid_q;
  assign S_AXI_RDATA  = rdata_q;
  assign S_AXI_RRESP  = rresp_q;
  assign b1_req       = b1_req_q;
  assign b1_index     = b1_index_q;
  assign b1_field     = b1_field_q;
  assign err_cnt      = err_cnt_q;

endmodule

// File: tb/tb_s_axi_read_banked.sv
// Self-checking bench for s_axi_read_banked: table of single reads plus
// hand-written bank1 wait/timeout, back-to-back and reset-abort sequences.
module tb_s_axi_read_banked;

  localparam logic [31:0] VER = 32'h0002_0000;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] araddr;
  logic        arvalid, arready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rvalid, rready;
  logic [3:0]  bank0_status;
  logic [1:0]  bank0_main_cnt, bank0_end_cnt;
  logic        b1_req;
  logic [1:0]  b1_index;
  logic [3:0]  b1_field;
  logic [31:0] b1_rdata;
  logic        b1_ready;
  logic [15:0] err_cnt;

  always #5 clk = ~clk;

  s_axi_read_banked dut (
    .clk(clk), .reset(reset),
    .S_AXI_ARADDR(araddr), .S_AXI_ARVALID(arvalid), .S_AXI_ARREADY(arready),
    .S_AXI_RDATA(rdata), .S_AXI_RRESP(rresp), .S_AXI_RVALID(rvalid), .S_AXI_RREADY(rready),
    .bank0_status(bank0_status), .bank0_main_cnt(bank0_main_cnt), .bank0_end_cnt(bank0_end_cnt),
    .b1_req(b1_req), .b1_index(b1_index), .b1_field(b1_field),
    .b1_rdata(b1_rdata), .b1_ready(b1_ready), .err_cnt(err_cnt)
  );

  typedef struct {
    logic [15:0] addr;
    logic [3:0]  status;
    logic [1:0]  main_cnt;
    logic [1:0]  end_cnt;
    logic [31:0] exp_data;
    logic [1:0]  exp_resp;
  } vec_t;

  typedef struct {
    logic [31:0] data;
    logic [1:0]  resp;
  } exp_t;

  exp_t sb[$];
  exp_t e;
  vec_t vecs[10];
  int checks = 0;
  int failures = 0;
  int model_err = 0;
  int b1_cycles = 0;
  int b1_age = 0;
  int b1_delay = -1;
  int stab_err = 0;
  logic [1:0] exp_idx = '0;
  logic [3:0] exp_fld = '0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // R-channel scoreboard and bank1 request observer.
  always @(negedge clk) begin
    if (!reset && rvalid && rready) begin
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_r: got rdata=%0h rresp=%0h expected no response", rdata, rresp);
      end else begin
        e = sb.pop_front();
        chk("rdata", 64'(rdata), 64'(e.data));
        chk("rresp", 64'(rresp), 64'(e.resp));
        if (e.resp != 2'b00 && model_err < 65535) model_err++;
      end
    end
    if (b1_req) begin
      b1_cycles++;
      b1_age++;
      if (b1_index !== exp_idx || b1_field !== exp_fld) stab_err++;
    end else begin
      b1_age = 0;
    end
  end

  // Bank1 responder: raises b1_ready b1_delay cycles after b1_req rises.
  always @(posedge clk) begin
    #1;
    b1_ready = (b1_delay >= 0) && b1_req && (b1_age == b1_delay);
  end

  task automatic ar_send(input logic [15:0] addr);
    int n;
    araddr  = addr;
    arvalid = 1'b1;
    n = 0;
    @(negedge clk);
    while (!arready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!arready) begin
      checks++;
      failures++;
      $display("FAIL ar_timeout: got arready=0 expected 1 for addr %0h", addr);
    end
    @(posedge clk);
    #1;
    arvalid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("drain_pending", 64'(sb.size()), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1);
  end

  initial begin
    vecs[0] = '{16'h0000, 4'h0, 2'd0, 2'd0, VER,          2'b00};
    vecs[1] = '{16'h0040, 4'hA, 2'd0, 2'd0, 32'h0000_000A, 2'b00};
    vecs[2] = '{16'h0080, 4'h1, 2'd3, 2'd0, 32'h0000_0003, 2'b00};
    vecs[3] = '{16'h00C0, 4'h1, 2'd2, 2'd1, 32'h0000_0001, 2'b00};
    vecs[4] = '{16'h0100, 4'hF, 2'd3, 2'd3, 32'h0,         2'b10};
    vecs[5] = '{16'h3FC0, 4'hF, 2'd3, 2'd3, 32'h0,         2'b10};
    vecs[6] = '{16'h8000, 4'hF, 2'd3, 2'd3, 32'h0,         2'b11};
    vecs[7] = '{16'hC040, 4'hF, 2'd3, 2'd3, 32'h0,         2'b11};
    vecs[8] = '{16'h4018, 4'hF, 2'd3, 2'd3, 32'h0,         2'b10};
    vecs[9] = '{16'h403C, 4'hF, 2'd3, 2'd3, 32'h0,         2'b10};

    reset = 1'b1; arvalid = 1'b1; araddr = 16'h0000; rready = 1'b1;
    bank0_status = '0; bank0_main_cnt = '0; bank0_end_cnt = '0;
    b1_rdata = 32'hDEAD_BEEF; b1_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_arready", 64'(arready), 64'd0);
    chk("rst_rvalid", 64'(rvalid), 64'd0);
    chk("rst_rdata", 64'(rdata), 64'd0);
    chk("rst_rresp", 64'(rresp), 64'd0);
    chk("rst_b1_req", 64'(b1_req), 64'd0);
    chk("rst_b1_index", 64'(b1_index), 64'd0);
    chk("rst_b1_field", 64'(b1_field), 64'd0);
    chk("rst_err_cnt", 64'(err_cnt), 64'd0);
    @(posedge clk);
    #1;
    arvalid = 1'b0;
    reset = 1'b0;

    // Single reads with RREADY held high: one-cycle latency then handshake.
    b1_cycles = 0;
    for (int i = 0; i < 10; i++) begin
      bank0_status   = vecs[i].status;
      bank0_main_cnt = vecs[i].main_cnt;
      bank0_end_cnt  = vecs[i].end_cnt;
      sb.push_back('{vecs[i].exp_data, vecs[i].exp_resp});
      ar_send(vecs[i].addr);
      @(negedge clk);
      chk("latency_rvalid", 64'(rvalid), 64'd1);
      @(posedge clk);
      #1;
      drain();
    end
    chk("no_b1_req_bad_field", 64'(b1_cycles), 64'd0);
    chk("err_cnt_table", 64'(err_cnt), 64'(model_err));

    // Bank1 read answered 3 cycles after b1_req.
    b1_cycles = 0; stab_err = 0;
    exp_idx = 2'd3; exp_fld = 4'd2; b1_delay = 3;
    sb.push_back('{32'hDEAD_BEEF, 2'b00});
    ar_send(16'h40C8);
    drain();
    chk("b1_req_cycles", 64'(b1_cycles), 64'd4);
    chk("b1_stable", 64'(stab_err), 64'd0);
    chk("b1_index", 64'(b1_index), 64'd3);
    chk("b1_field", 64'(b1_field), 64'd2);
    chk("b1_req_low", 64'(b1_req), 64'd0);

    // Bank1 read never answered: timeout after TIMEOUT cycles.
    b1_cycles = 0; stab_err = 0;
    exp_idx = 2'd0; exp_fld = 4'd0; b1_delay = -1;
    sb.push_back('{32'h0, 2'b10});
    ar_send(16'h4000);
    drain();
    chk("timeout_b1_cycles", 64'(b1_cycles), 64'd16);
    chk("timeout_stable", 64'(stab_err), 64'd0);
    chk("err_cnt_timeout", 64'(err_cnt), 64'(model_err));

    // DECERR held under backpressure, then back-to-back acceptance.
    rready = 1'b0;
    sb.push_back('{32'h0, 2'b11});
    ar_send(16'h8000);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("hold_rvalid", 64'(rvalid), 64'd1);
      chk("hold_rresp", 64'(rresp), 64'd3);
      chk("hold_rdata", 64'(rdata), 64'd0);
    end
    @(posedge clk);
    #1;
    rready = 1'b1; araddr = 16'h0000; arvalid = 1'b1;
    sb.push_back('{VER, 2'b00});
    @(negedge clk);
    chk("b2b_arready", 64'(arready), 64'd1);
    @(posedge clk);
    #1;
    arvalid = 1'b0;
    @(negedge clk);
    chk("b2b_rvalid", 64'(rvalid), 64'd1);
    @(posedge clk);
    #1;
    drain();
    chk("err_cnt_decerr", 64'(err_cnt), 64'(model_err));

    // Reset while waiting on bank1 aborts the read.
    exp_idx = 2'd1; exp_fld = 4'd0; b1_delay = -1;
    sb.push_back('{32'h0, 2'b10});
    ar_send(16'h4040);
    @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    sb.delete();
    model_err = 0;
    chk("abort_b1_req", 64'(b1_req), 64'd0);
    chk("abort_rvalid", 64'(rvalid), 64'd0);
    chk("abort_err_cnt", 64'(err_cnt), 64'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    bank0_status = 4'h5;
    sb.push_back('{32'h0000_0005, 2'b00});
    ar_send(16'h0040);
    drain();
    chk("post_reset_err_cnt", 64'(err_cnt), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
